writeback_stage: RTL and testbench
==================================

// Module: writeback_stage
// PURPOSE
// Final pipeline stage; sits directly downstream of the memory stage and consumes its outputs.
// Latches one retiring instruction per memory_done pulse and selects ALU or load data.
// Sign/zero-extends the load data and drives the register-file write port.
// Clears the destination's scoreboard bit, blocks on ECALL until the handler returns,
// and counts retired instructions.
// PARAMETERS
// XLEN        64   datapath width; only 64 is supported
// CNT_W       64   width of retired-instruction counter
// PORTS
// clk                  in   1      clock
// reset                in   1      synchronous, active-high reset
// memory_done          in   1      memory stage result valid (1-cycle pulse)
// control_signals      in   64     [4:0] rd, [5] reg_write, [6] mem_to_reg, [9:7] funct3, [10] ecall
// alu_data             in   64     ALU result; [2:0] = load byte offset
// loaded_data          in   64     aligned doubleword returned by the memory stage
// wb_ready             out  1      stage can accept memory_done this cycle
// rf_write_en          out  1      register-file write strobe
// rf_write_addr        out  5      destination register
// rf_write_data        out  64     write-back value
// sb_clear_valid       out  1      scoreboard clear strobe
// sb_clear_reg         out  5      register whose busy bit clears
// ecall_req            out  1      request to the ECALL handler (level)
// ecall_done           in   1      handler completion pulse
// retired_count        out  CNT_W  instructions retired since reset
// BEHAVIOUR
// - Reset: state=IDLE, wb_ready=1, all strobes=0, addr/data=0, ecall_req=0, retired_count=0.
// - FSM states: IDLE, WRITE, ECALL_WAIT.
//   - IDLE: when memory_done && wb_ready, capture the inputs and go to WRITE.
//   - WRITE, if ecall=0: assert write/clear strobes for exactly 1 cycle, retired_count+=1,
//     then go to IDLE.
//   - WRITE, if ecall=1: go to ECALL_WAIT without any write.
//   - ECALL_WAIT: ecall_req=1 until ecall_done is sampled high. Then retired_count+=1,
//     sb_clear_valid pulses only if reg_write && rd!=0, and go to IDLE.
// - wb_ready=1 only in IDLE. memory_done while not ready is an upstream protocol error:
//   ignore it and flag it with an assertion.
// - Latency: memory_done in cycle N -> rf_write_en in cycle N+1. Throughput is 1 per 2 cycles.
// - Result select: mem_to_reg=0 -> alu_data; mem_to_reg=1 -> extended load.
// - Load extension: shifted = loaded_data >> (8*alu_data[2:0]).
//   - funct3 000 LB:  sext(shifted[7:0])
//   - funct3 001 LH:  sext(shifted[15:0])
//   - funct3 010 LW:  sext(shifted[31:0])
//   - funct3 011 LD:  shifted
//   - funct3 100 LBU: zext(shifted[7:0])
//   - funct3 101 LHU: zext(shifted[15:0])
//   - funct3 110 LWU: zext(shifted[31:0])
//   - funct3 111: illegal; write 0.
// - Misaligned offsets (e.g. LW at offset 6) are not checked here. The high bytes shift
//   in as zeros before extension.
// - rd==0 or reg_write==0: rf_write_en stays 0 and sb_clear_valid stays 0, but the
//   instruction still counts as retired.
// - sb_clear_valid and rf_write_en assert in the same cycle with the same register.
// - retired_count wraps modulo 2^CNT_W.
// - ecall_done in any state other than ECALL_WAIT is ignored.
// - Reset in any state returns to the reset values next cycle. Any pending write is dropped.
// TESTING
// - ALU op: rd=5, reg_write=1, alu_data=0x1234 -> next cycle write_en=1, addr=5,
//   data=0x1234, clear 5, count=1.
// - LB at offset 3, loaded_data=0x0000_0000_8000_0000 -> data=0xFFFF_FFFF_FFFF_FF80;
//   the same access as LBU -> data=0x80.
// - LWU at offset 4, loaded_data=0xDEADBEEF_00000000 -> data=0x0000_0000_DEAD_BEEF;
//   as LW -> 0xFFFF_FFFF_DEAD_BEEF.
// - rd=0 with reg_write=1 -> no rf_write_en and no sb_clear_valid; count still increments.
// - ECALL with rd=10: ecall_req high, wb_ready low for 5 cycles. On ecall_done,
//   count+=1 and clear 10 with no rf write. A memory_done held during the wait is dropped.
// - Reset asserted in ECALL_WAIT -> ecall_req=0, wb_ready=1, count=0 next cycle;
//   back-to-back ops then retire every 2 cycles.

Source files
------------

// File: rtl/writeback_stage_if.sv
// Bundle between the memory stage, the write-back stage, the register file,
// the scoreboard and the ECALL handler.
interface writeback_stage_if #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 64
);
  logic              memory_done;
  logic [63:0]       control_signals;
  logic [XLEN-1:0]   alu_data;
  logic [XLEN-1:0]   loaded_data;
  logic              wb_ready;
  logic              rf_write_en;
  logic [4:0]        rf_write_addr;
  logic [XLEN-1:0]   rf_write_data;
  logic              sb_clear_valid;
  logic [4:0]        sb_clear_reg;
  logic              ecall_req;
  logic              ecall_done;
  logic [CNT_W-1:0]  retired_count;

  modport master (
    output memory_done, control_signals, alu_data, loaded_data, ecall_done,
    input  wb_ready, rf_write_en, rf_write_addr, rf_write_data,
           sb_clear_valid, sb_clear_reg, ecall_req, retired_count
  );

  modport slave (
    input  memory_done, control_signals, alu_data, loaded_data, ecall_done,
    output wb_ready, rf_write_en, rf_write_addr, rf_write_data,
           sb_clear_valid, sb_clear_reg, ecall_req, retired_count
  );
endinterface

// File: rtl/writeback_stage.sv
// Final pipeline stage: retires one instruction per memory_done, drives the
// register-file write port and scoreboard clear, and parks on ECALL.
module writeback_stage_chk (
  input logic       clk,
  input logic       reset,
  input logic       memory_done,
  input logic       wb_ready,
  input logic       rf_write_en,
  input logic [4:0] rf_write_addr,
  input logic       sb_clear_valid,
  input logic [4:0] sb_clear_reg
);
  // Upstream must not pulse memory_done while busy; such pulses are dropped.
  always @(posedge clk) begin
    if (!reset) begin
      assert (!(memory_done && !wb_ready))
        else $warning("writeback_stage: memory_done while wb_ready low, dropped");
      assert (!rf_write_en || (sb_clear_valid && (sb_clear_reg == rf_write_addr)))
        else $error("writeback_stage: rf write without matching scoreboard clear");
    end
  end
endmodule

module writeback_stage #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 64
) (
  input logic          clk,
  input logic          reset,
  writeback_stage_if.slave wb
);
  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WRITE      = 2'd1,
    ST_ECALL_WAIT = 2'd2
  } state_t;

  function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] raw,
                                                   input logic [2:0]      offset,
                                                   input logic [2:0]      funct3);
    logic [XLEN-1:0] shifted;
    shifted = raw >> {offset, 3'b000};
    case (funct3)
      3'b000:  load_extend = {{56{shifted[7]}},  shifted[7:0]};
      3'b001:  load_extend = {{48{shifted[15]}}, shifted[15:0]};
      3'b010:  load_extend = {{32{shifted[31]}}, shifted[31:0]};
      3'b011:  load_extend = shifted;
      3'b100:  load_extend = {56'd0, shifted[7:0]};
      3'b101:  load_extend = {48'd0, shifted[15:0]};
      3'b110:  load_extend = {32'd0, shifted[31:0]};
      default: load_extend = {XLEN{1'b0}};
    endcase
  endfunction

  state_t           state_r, state_nxt_s;
  logic [4:0]       rd_r, rd_nxt_s;
  logic             reg_write_r, reg_write_nxt_s;
  logic             ecall_r, ecall_nxt_s;
  logic             wb_ready_r, wb_ready_nxt_s;
  logic             rf_write_en_r, rf_write_en_nxt_s;
  logic [4:0]       rf_write_addr_r, rf_write_addr_nxt_s;
  logic [XLEN-1:0]  rf_write_data_r, rf_write_data_nxt_s;
  logic             sb_clear_valid_r, sb_clear_valid_nxt_s;
  logic [4:0]       sb_clear_reg_r, sb_clear_reg_nxt_s;
  logic             ecall_req_r, ecall_req_nxt_s;
  logic [CNT_W-1:0] retired_count_r, retired_count_nxt_s;

  logic [4:0]       in_rd_s;
  logic             in_reg_write_s;
  logic             in_mem_to_reg_s;
  logic [2:0]       in_funct3_s;
  logic             in_ecall_s;
  logic             in_writes_s;
  logic [XLEN-1:0]  in_result_s;
  logic             unused_ctrl_s;

  assign in_rd_s         = wb.control_signals[4:0];
  assign in_reg_write_s  = wb.control_signals[5];
  assign in_mem_to_reg_s = wb.control_signals[6];
  assign in_funct3_s     = wb.control_signals[9:7];
  assign in_ecall_s      = wb.control_signals[10];
  assign unused_ctrl_s   = ^wb.control_signals[63:11];
  assign in_writes_s     = in_reg_write_s && (in_rd_s != 5'd0);

  // Result mux: the whole write-back value is formed from the live inputs at capture.
  always_comb begin
    in_result_s = wb.alu_data;
    if (in_mem_to_reg_s) begin
      in_result_s = load_extend(wb.loaded_data, wb.alu_data[2:0], in_funct3_s);
    end else begin
      in_result_s = wb.alu_data;
    end
  end

  // Next-state and next-output logic; all outputs are registered so strobes
  // appear the cycle after the capturing memory_done.
  always_comb begin
    state_nxt_s          = state_r;
    rd_nxt_s             = rd_r;
    reg_write_nxt_s      = reg_write_r;
    ecall_nxt_s          = ecall_r;
    wb_ready_nxt_s       = 1'b0;
    rf_write_en_nxt_s    = 1'b0;
    rf_write_addr_nxt_s  = rf_write_addr_r;
    rf_write_data_nxt_s  = rf_write_data_r;
    sb_clear_valid_nxt_s = 1'b0;
    sb_clear_reg_nxt_s   = sb_clear_reg_r;
    ecall_req_nxt_s      = 1'b0;
    retired_count_nxt_s  = retired_count_r;
    case (state_r)
      ST_IDLE: begin
        if (wb.memory_done && wb_ready_r) begin
          state_nxt_s     = ST_WRITE;
          rd_nxt_s        = in_rd_s;
          reg_write_nxt_s = in_reg_write_s;
          ecall_nxt_s     = in_ecall_s;
          if (!in_ecall_s) begin
            retired_count_nxt_s = retired_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            if (in_writes_s) begin
              rf_write_en_nxt_s    = 1'b1;
              rf_write_addr_nxt_s  = in_rd_s;
              rf_write_data_nxt_s  = in_result_s;
              sb_clear_valid_nxt_s = 1'b1;
              sb_clear_reg_nxt_s   = in_rd_s;
            end else begin
              rf_write_en_nxt_s    = 1'b0;
            end
          end else begin
            retired_count_nxt_s = retired_count_r;
          end
        end else begin
          wb_ready_nxt_s = 1'b1;
        end
      end
      ST_WRITE: begin
        if (ecall_r) begin
          state_nxt_s     = ST_ECALL_WAIT;
          ecall_req_nxt_s = 1'b1;
        end else begin
          state_nxt_s    = ST_IDLE;
          wb_ready_nxt_s = 1'b1;
        end
      end
      ST_ECALL_WAIT: begin
        if (wb.ecall_done) begin
          state_nxt_s          = ST_IDLE;
          wb_ready_nxt_s       = 1'b1;
          retired_count_nxt_s  = retired_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
          sb_clear_valid_nxt_s = reg_write_r && (rd_r != 5'd0);
          sb_clear_reg_nxt_s   = rd_r;
        end else begin
          ecall_req_nxt_s = 1'b1;
        end
      end
      default: begin
        state_nxt_s    = ST_IDLE;
        wb_ready_nxt_s = 1'b1;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r          <= ST_IDLE;
      rd_r             <= 5'd0;
      reg_write_r      <= 1'b0;
      ecall_r          <= 1'b0;
      wb_ready_r       <= 1'b1;
      rf_write_en_r    <= 1'b0;
      rf_write_addr_r  <= 5'd0;
      rf_write_data_r  <= {XLEN{1'b0}};
      sb_clear_valid_r <= 1'b0;
      sb_clear_reg_r   <= 5'd0;
      ecall_req_r      <= 1'b0;
      retired_count_r  <= {CNT_W{1'b0}};
    end else begin
      state_r          <= state_nxt_s;
      rd_r             <= rd_nxt_s;
      reg_write_r      <= reg_write_nxt_s;
      ecall_r          <= ecall_nxt_s;
      wb_ready_r       <= wb_ready_nxt_s;
      rf_write_en_r    <= rf_write_en_nxt_s;
      rf_write_addr_r  <= rf_write_addr_nxt_s;
      rf_write_data_r  <= rf_write_data_nxt_s;
      sb_clear_valid_r <= sb_clear_valid_nxt_s;
      sb_clear_reg_r   <= sb_clear_reg_nxt_s;
      ecall_req_r      <= ecall_req_nxt_s;
      retired_count_r  <= retired_count_nxt_s;
    end
  end

  assign wb.wb_ready       = wb_ready_r;
  assign wb.rf_write_en    = rf_write_en_r;
  assign wb.rf_write_addr  = rf_write_addr_r;
  assign wb.rf_write_data  = rf_write_data_r;
  assign wb.sb_clear_valid = sb_clear_valid_r;
  assign wb.sb_clear_reg   = sb_clear_reg_r;
  assign wb.ecall_req      = ecall_req_r;
  assign wb.retired_count  = retired_count_r;

  writeback_stage_chk u_chk (
    .clk            (clk),
    .reset          (reset),
    .memory_done    (wb.memory_done),
    .wb_ready       (wb_ready_r),
    .rf_write_en    (rf_write_en_r),
    .rf_write_addr  (rf_write_addr_r),
    .sb_clear_valid (sb_clear_valid_r),
    .sb_clear_reg   (sb_clear_reg_r)
  );
endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: ALU/load retire, extension, rd=0, ECALL
// wait with dropped memory_done, reset mid-ECALL and back-to-back throughput.
module tb_writeback_stage;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  writeback_stage_if #(.XLEN(64), .CNT_W(64)) wb_if ();

  writeback_stage #(.XLEN(64), .CNT_W(64)) dut (
    .clk   (clk),
    .reset (reset),
    .wb    (wb_if.slave)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  function automatic logic [63:0] ctrl(input logic [4:0] rd, input logic rw,
                                       input logic m2r, input logic [2:0] f3,
                                       input logic ec);
    ctrl = {53'd0, ec, f3, m2r, rw, rd};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed=0x%h expected=0x%h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [63:0] c, input logic [63:0] alu, input logic [63:0] ld);
    wb_if.control_signals = c;
    wb_if.alu_data        = alu;
    wb_if.loaded_data     = ld;
    wb_if.memory_done     = 1'b1;
    tick();
    wb_if.memory_done     = 1'b0;
  endtask

  task automatic expect_write(input string tag, input logic [4:0] rd,
                              input logic [63:0] data, input logic [63:0] cnt);
    chk({tag, "_we"},   {63'd0, wb_if.rf_write_en}, 64'd1);
    chk({tag, "_addr"}, {59'd0, wb_if.rf_write_addr}, {59'd0, rd});
    chk({tag, "_data"}, wb_if.rf_write_data, data);
    chk({tag, "_sbv"},  {63'd0, wb_if.sb_clear_valid}, 64'd1);
    chk({tag, "_sbr"},  {59'd0, wb_if.sb_clear_reg}, {59'd0, rd});
    chk({tag, "_cnt"},  wb_if.retired_count, cnt);
    tick();
  endtask

  initial begin
    clk = 1'b0;
    checks = 0;
    errors = 0;
    reset = 1'b1;
    wb_if.memory_done = 1'b0;
    wb_if.control_signals = 64'd0;
    wb_if.alu_data = 64'd0;
    wb_if.loaded_data = 64'd0;
    wb_if.ecall_done = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("rst_ready", {63'd0, wb_if.wb_ready}, 64'd1);
    chk("rst_we",    {63'd0, wb_if.rf_write_en}, 64'd0);
    chk("rst_addr",  {59'd0, wb_if.rf_write_addr}, 64'd0);
    chk("rst_data",  wb_if.rf_write_data, 64'd0);
    chk("rst_sbv",   {63'd0, wb_if.sb_clear_valid}, 64'd0);
    chk("rst_ecall", {63'd0, wb_if.ecall_req}, 64'd0);
    chk("rst_cnt",   wb_if.retired_count, 64'd0);

    issue(ctrl(5'd5, 1'b1, 1'b0, 3'b000, 1'b0), 64'h1234, 64'd0);
    chk("alu_busy", {63'd0, wb_if.wb_ready}, 64'd0);
    expect_write("alu", 5'd5, 64'h1234, 64'd1);
    chk("alu_we_drop", {63'd0, wb_if.rf_write_en}, 64'd0);
    chk("alu_sb_drop", {63'd0, wb_if.sb_clear_valid}, 64'd0);
    chk("alu_ready",   {63'd0, wb_if.wb_ready}, 64'd1);

    issue(ctrl(5'd7, 1'b1, 1'b1, 3'b000, 1'b0), 64'd3, 64'h0000_0000_8000_0000);
    expect_write("lb", 5'd7, 64'hFFFF_FFFF_FFFF_FF80, 64'd2);
    issue(ctrl(5'd7, 1'b1, 1'b1, 3'b100, 1'b0), 64'd3, 64'h0000_0000_8000_0000);
    expect_write("lbu", 5'd7, 64'h0000_0000_0000_0080, 64'd3);
    issue(ctrl(5'd8, 1'b1, 1'b1, 3'b110, 1'b0), 64'd4, 64'hDEAD_BEEF_0000_0000);
    expect_write("lwu", 5'd8, 64'h0000_0000_DEAD_BEEF, 64'd4);
    issue(ctrl(5'd8, 1'b1, 1'b1, 3'b010, 1'b0), 64'd4, 64'hDEAD_BEEF_0000_0000);
    expect_write("lw", 5'd8, 64'hFFFF_FFFF_DEAD_BEEF, 64'd5);
    issue(ctrl(5'd31, 1'b1, 1'b1, 3'b011, 1'b0), 64'd0, 64'h0123_4567_89AB_CDEF);
    expect_write("ld", 5'd31, 64'h0123_4567_89AB_CDEF, 64'd6);
    issue(ctrl(5'd9, 1'b1, 1'b1, 3'b010, 1'b0), 64'd6, 64'hAABB_CCDD_1122_3344);
    expect_write("lw_misal", 5'd9, 64'h0000_0000_0000_AABB, 64'd7);
    issue(ctrl(5'd9, 1'b1, 1'b1, 3'b111, 1'b0), 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    expect_write("f3_illegal", 5'd9, 64'd0, 64'd8);

    issue(ctrl(5'd0, 1'b1, 1'b0, 3'b000, 1'b0), 64'h77, 64'd0);
    chk("rd0_we",  {63'd0, wb_if.rf_write_en}, 64'd0);
    chk("rd0_sbv", {63'd0, wb_if.sb_clear_valid}, 64'd0);
    chk("rd0_cnt", wb_if.retired_count, 64'd9);
    tick();
    issue(ctrl(5'd3, 1'b0, 1'b0, 3'b000, 1'b0), 64'h88, 64'd0);
    chk("nowr_we",  {63'd0, wb_if.rf_write_en}, 64'd0);
    chk("nowr_cnt", wb_if.retired_count, 64'd10);
    tick();

    issue(ctrl(5'd10, 1'b1, 1'b0, 3'b000, 1'b1), 64'h55, 64'd0);
    chk("ec_we",    {63'd0, wb_if.rf_write_en}, 64'd0);
    chk("ec_ready", {63'd0, wb_if.wb_ready}, 64'd0);
    tick();
    chk("ec_req1", {63'd0, wb_if.ecall_req}, 64'd1);
    wb_if.control_signals = ctrl(5'd20, 1'b1, 1'b0, 3'b000, 1'b0);
    wb_if.alu_data = 64'h99;
    wb_if.memory_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ec_req_hold",   {63'd0, wb_if.ecall_req}, 64'd1);
      chk("ec_ready_hold", {63'd0, wb_if.wb_ready}, 64'd0);
      chk("ec_cnt_hold",   wb_if.retired_count, 64'd10);
    end
    wb_if.memory_done = 1'b0;
    wb_if.ecall_done = 1'b1;
    tick();
    wb_if.ecall_done = 1'b0;
    chk("ec_done_req",   {63'd0, wb_if.ecall_req}, 64'd0);
    chk("ec_done_ready", {63'd0, wb_if.wb_ready}, 64'd1);
    chk("ec_done_sbv",   {63'd0, wb_if.sb_clear_valid}, 64'd1);
    chk("ec_done_sbr",   {59'd0, wb_if.sb_clear_reg}, 64'd10);
    chk("ec_done_we",    {63'd0, wb_if.rf_write_en}, 64'd0);
    chk("ec_done_cnt",   wb_if.retired_count, 64'd11);
    tick();
    chk("ec_drop_addr", {59'd0, wb_if.rf_write_addr}, 64'd9);
    chk("ec_drop_cnt",  wb_if.retired_count, 64'd11);

    wb_if.ecall_done = 1'b1;
    tick();
    wb_if.ecall_done = 1'b0;
    chk("stray_done_cnt", wb_if.retired_count, 64'd11);
    chk("stray_done_sbv", {63'd0, wb_if.sb_clear_valid}, 64'd0);

    issue(ctrl(5'd10, 1'b1, 1'b0, 3'b000, 1'b1), 64'd0, 64'd0);
    tick();
    chk("rst_ec_req_pre", {63'd0, wb_if.ecall_req}, 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_ec_req",   {63'd0, wb_if.ecall_req}, 64'd0);
    chk("rst_ec_ready", {63'd0, wb_if.wb_ready}, 64'd1);
    chk("rst_ec_cnt",   wb_if.retired_count, 64'd0);

    for (int i = 0; i < 3; i++) begin
      issue(ctrl(5'(i + 1), 1'b1, 1'b0, 3'b000, 1'b0), 64'h100 + 64'(i), 64'd0);
      expect_write("b2b", 5'(i + 1), 64'h100 + 64'(i), 64'(i + 1));
      chk("b2b_ready", {63'd0, wb_if.wb_ready}, 64'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
